// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN CRC types, polynomials, field lengths and fixed-stuff-bit positions
package can_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_CRC_RX = 2'd2,
    ST_DONE   = 2'd3
  } crc_state_t;

  // Generator polynomials without the implicit top term
  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam logic [16:0] CRC17_POLY = 17'h1685B;
  localparam logic [20:0] CRC21_POLY = 21'h102899;

  localparam logic [16:0] CRC17_INIT_ISO = 17'h10000;
  localparam logic [20:0] CRC21_INIT_ISO = 21'h100000;

  localparam logic [4:0] FIELD_LEN15 = 5'd15;
  localparam logic [4:0] FIELD_LEN17 = 5'd22;
  localparam logic [4:0] FIELD_LEN21 = 5'd27;

  // One bit per field position: 0, 5, 10, 15, 20, 25
  localparam logic [31:0] FSB_MASK = 32'h0210_8421;

  function automatic logic is_fsb(input logic [4:0] pos);
    return FSB_MASK[pos];
  endfunction

endpackage

// File: rtl/can_crc_seq_if.sv
// rtl/can_crc_seq_if.sv - bit-stream and result signals of the CAN CRC sequencer
interface can_crc_seq_if;
  logic        sample_point;
  logic        sampled_bit;
  logic        stuff_bit;
  logic        sof;
  logic        fd_frame;
  logic        fd_iso;
  logic [3:0]  dlc;
  logic        crc_start;
  logic        frame_abort;
  logic        busy;
  logic        crc_done;
  logic        crc_err;
  logic        fsb_err;
  logic [20:0] crc_calc;

  modport master (
    output sample_point, sampled_bit, stuff_bit, sof, fd_frame, fd_iso, dlc,
           crc_start, frame_abort,
    input  busy, crc_done, crc_err, fsb_err, crc_calc
  );

  modport slave (
    input  sample_point, sampled_bit, stuff_bit, sof, fd_frame, fd_iso, dlc,
           crc_start, frame_abort,
    output busy, crc_done, crc_err, fsb_err, crc_calc
  );
endinterface

// File: rtl/can_crc.sv
// rtl/can_crc.sv - bit-serial CRC15/CRC17/CRC21 engine, all three updated in parallel
module can_crc
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        i_init,
  input  logic        i_fd_iso,
  input  logic        i_enable,
  input  logic        i_data,
  input  logic        i_stuff,
  output logic [14:0] o_crc15,
  output logic [16:0] o_crc17,
  output logic [20:0] o_crc21
);

  logic [14:0] r_crc15;
  logic [16:0] r_crc17;
  logic [20:0] r_crc21;
  logic        w_fb15;
  logic        w_fb17;
  logic        w_fb21;

  assign w_fb15 = i_data ^ r_crc15[14];
  assign w_fb17 = i_data ^ r_crc17[16];
  assign w_fb21 = i_data ^ r_crc21[20];

  // Classic CRC15 skips dynamic stuff bits; the FD CRCs cover them
  always_ff @(posedge clk) begin
    if (i_init) begin
      r_crc15 <= '0;
      r_crc17 <= i_fd_iso ? CRC17_INIT_ISO : '0;
      r_crc21 <= i_fd_iso ? CRC21_INIT_ISO : '0;
    end else if (i_enable) begin
      if (!i_stuff) begin
        r_crc15 <= {r_crc15[13:0], 1'b0} ^ (w_fb15 ? CRC15_POLY : 15'd0);
      end
      r_crc17 <= {r_crc17[15:0], 1'b0} ^ (w_fb17 ? CRC17_POLY : 17'd0);
      r_crc21 <= {r_crc21[19:0], 1'b0} ^ (w_fb21 ? CRC21_POLY : 21'd0);
    end
  end

  assign o_crc15 = r_crc15;
  assign o_crc17 = r_crc17;
  assign o_crc21 = r_crc21;

endmodule

// File: rtl/can_crc_seq.sv
// rtl/can_crc_seq.sv - CAN CRC sequencer: drives the CRC engine, receives and checks the CRC field
module can_crc_seq
  import can_pkg::*;
#(
  parameter logic [3:0] CRC_SEL_DLC = 4'd10
) (
  input  logic         clk,
  input  logic         rst,
  can_crc_seq_if.slave bus
);

  crc_state_t  r_state;
  crc_state_t  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  r_len;
  logic [20:0] r_shift;
  logic [20:0] r_calc;
  logic        r_fd;
  logic        r_prev_bit;
  logic        r_crc_done;
  logic        r_crc_err;
  logic        r_fsb_err;

  logic        w_eng_init;
  logic        w_eng_iso;
  logic        w_eng_en;
  logic        w_start;
  logic        w_field_bit;
  logic        w_done_evt;
  logic        w_fsb_pos;
  logic [14:0] w_crc15;
  logic [16:0] w_crc17;
  logic [20:0] w_crc21;
  logic [20:0] w_sel_crc;
  logic [4:0]  w_sel_len;

  can_crc u_crc (
    .clk      (clk),
    .i_init   (w_eng_init),
    .i_fd_iso (w_eng_iso),
    .i_enable (w_eng_en),
    .i_data   (bus.sampled_bit),
    .i_stuff  (bus.stuff_bit),
    .o_crc15  (w_crc15),
    .o_crc17  (w_crc17),
    .o_crc21  (w_crc21)
  );

  always_comb begin
    w_sel_crc = {6'd0, w_crc15};
    w_sel_len = FIELD_LEN15;
    if (bus.fd_frame) begin
      if (bus.dlc <= CRC_SEL_DLC) begin
        w_sel_crc = {4'd0, w_crc17};
        w_sel_len = FIELD_LEN17;
      end else begin
        w_sel_crc = w_crc21;
        w_sel_len = FIELD_LEN21;
      end
    end
  end

  assign w_fsb_pos = r_fd && is_fsb(r_cnt);

  // sof restarts from any state and wins over frame_abort
  always_comb begin
    w_state_nxt = r_state;
    w_eng_init  = 1'b0;
    w_eng_iso   = 1'b0;
    w_eng_en    = 1'b0;
    w_start     = 1'b0;
    w_field_bit = 1'b0;
    w_done_evt  = 1'b0;
    if (rst) begin
      w_state_nxt = ST_IDLE;
      w_eng_init  = 1'b1;
    end else if (bus.sof) begin
      w_state_nxt = ST_CALC;
      w_eng_init  = 1'b1;
      w_eng_iso   = bus.fd_iso;
    end else begin
      case (r_state)
        ST_CALC: begin
          if (bus.frame_abort) begin
            w_state_nxt = ST_IDLE;
          end else if (bus.crc_start) begin
            w_start     = 1'b1;
            w_state_nxt = ST_CRC_RX;
          end else if (bus.sample_point) begin
            w_eng_en = 1'b1;
          end
        end
        ST_CRC_RX: begin
          if (bus.frame_abort) begin
            w_state_nxt = ST_IDLE;
          end else if (bus.sample_point) begin
            w_field_bit = 1'b1;
            if (r_cnt == r_len - 5'd1) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_done_evt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
  end

  // The crc_start bit is field bit 0: a fixed stuff bit in FD, the CRC MSB in classic
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      r_calc     <= '0;
      r_fd       <= 1'b0;
      r_prev_bit <= 1'b0;
      r_crc_done <= 1'b0;
      r_crc_err  <= 1'b0;
      r_fsb_err  <= 1'b0;
    end else begin
      r_crc_done <= w_done_evt;
      if (bus.sof) begin
        r_crc_err <= 1'b0;
        r_fsb_err <= 1'b0;
      end
      if (w_done_evt) begin
        r_crc_err <= (r_shift != r_calc);
      end
      if (w_eng_en) begin
        r_prev_bit <= bus.sampled_bit;
      end
      if (w_start) begin
        r_calc     <= w_sel_crc;
        r_len      <= w_sel_len;
        r_fd       <= bus.fd_frame;
        r_cnt      <= 5'd1;
        r_prev_bit <= bus.sampled_bit;
        if (bus.fd_frame) begin
          r_shift <= '0;
          if (bus.sampled_bit == r_prev_bit) begin
            r_fsb_err <= 1'b1;
          end
        end else begin
          r_shift <= {20'd0, bus.sampled_bit};
        end
      end
      if (w_field_bit) begin
        r_cnt      <= r_cnt + 5'd1;
        r_prev_bit <= bus.sampled_bit;
        if (w_fsb_pos) begin
          if (bus.sampled_bit == r_prev_bit) begin
            r_fsb_err <= 1'b1;
          end
        end else begin
          r_shift <= {r_shift[19:0], bus.sampled_bit};
        end
      end
    end
  end

  assign bus.busy     = (r_state == ST_CALC) || (r_state == ST_CRC_RX);
  assign bus.crc_done = r_crc_done;
  assign bus.crc_err  = r_crc_err;
  assign bus.fsb_err  = r_fsb_err;
  assign bus.crc_calc = r_calc;

endmodule

// File: tb/tb_can_crc_seq.sv
// tb/tb_can_crc_seq.sv - self-checking bench for can_crc_seq against a polynomial-division model
module tb_can_crc_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  can_crc_seq_if bus ();

  can_crc_seq #(.CRC_SEL_DLC(4'd10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic        exp_busy;
  logic        exp_done;
  logic        exp_crc_err;
  logic        exp_fsb_err;
  logic [20:0] exp_calc;
  bit          calc_bits[$];
  bit          calc_stuff[$];

  task automatic cmp(input string name, input logic [20:0] act, input logic [20:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy",     {20'd0, bus.busy},     {20'd0, exp_busy});
      cmp("crc_done", {20'd0, bus.crc_done}, {20'd0, exp_done});
      cmp("crc_err",  {20'd0, bus.crc_err},  {20'd0, exp_crc_err});
      cmp("fsb_err",  {20'd0, bus.fsb_err},  {20'd0, exp_fsb_err});
      cmp("crc_calc", bus.crc_calc,          exp_calc);
    end
  end

  // CRC = (init * x^n + M * x^w) mod G, by long division over a bit array
  function automatic logic [20:0] model_crc(input int w, input logic [21:0] g,
                                            input logic [20:0] init, input bit skip_stuff);
    bit d [0:127];
    bit m [$];
    int n;
    logic [20:0] r;
    foreach (calc_bits[i]) if (!(skip_stuff && calc_stuff[i])) m.push_back(calc_bits[i]);
    n = m.size();
    for (int i = 0; i < 128; i++) d[i] = 1'b0;
    foreach (m[i]) d[n - 1 - i + w] = m[i];
    for (int j = 0; j < w; j++) d[n + j] = d[n + j] ^ init[j];
    for (int deg = n + w - 1; deg >= w; deg--) begin
      if (d[deg]) begin
        for (int j = 0; j <= w; j++) d[deg - w + j] = d[deg - w + j] ^ g[j];
      end
    end
    r = '0;
    for (int j = 0; j < w; j++) r[j] = d[j];
    return r;
  endfunction

  task automatic clr();
    bus.sample_point = 1'b0;
    bus.sampled_bit  = 1'b0;
    bus.stuff_bit    = 1'b0;
    bus.sof          = 1'b0;
    bus.fd_frame     = 1'b0;
    bus.fd_iso       = 1'b0;
    bus.dlc          = 4'd0;
    bus.crc_start    = 1'b0;
    bus.frame_abort  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input bit in_rx);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      bus.fd_iso    = 1'($urandom_range(0, 1));
      bus.fd_frame  = 1'($urandom_range(0, 1));
      bus.dlc       = 4'($urandom_range(0, 15));
      bus.stuff_bit = 1'($urandom_range(0, 1));
      if (in_rx) bus.crc_start = 1'($urandom_range(0, 1));
      step();
      clr();
    end
  endtask

  task automatic noise_idle();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      bus.sample_point = 1'($urandom_range(0, 1));
      bus.sampled_bit  = 1'($urandom_range(0, 1));
      bus.crc_start    = 1'($urandom_range(0, 1));
      bus.fd_frame     = 1'($urandom_range(0, 1));
      bus.dlc          = 4'($urandom_range(0, 15));
      step();
      clr();
    end
  endtask

  task automatic set_bits(input int n, input bit val);
    calc_bits.delete();
    calc_stuff.delete();
    for (int i = 0; i < n; i++) begin
      calc_bits.push_back(val);
      calc_stuff.push_back(1'b0);
    end
  endtask

  task automatic send_frame(input bit fd, input bit iso, input logic [3:0] dl,
                            input logic [20:0] flip, input int bad_fsb, input int abort_pos,
                            input int rst_pos, input bit sof_abort);
    int w;
    int len;
    int k;
    logic [20:0] crc;
    logic [20:0] rx;
    bit prev;
    bit v;
    bit field[$];
    bit fsb_hit[$];
    if (!fd) begin
      w = 15; len = 15; crc = model_crc(15, 22'h00C599, 21'd0, 1'b1);
    end else if (dl <= 4'd10) begin
      w = 17; len = 22; crc = model_crc(17, 22'h03685B, iso ? 21'h10000 : 21'd0, 1'b0);
    end else begin
      w = 21; len = 27; crc = model_crc(21, 22'h302899, iso ? 21'h100000 : 21'd0, 1'b0);
    end
    rx = crc ^ flip;
    prev = calc_bits[calc_bits.size() - 1];
    k = 0;
    for (int p = 0; p < len; p++) begin
      if (fd && (p % 5 == 0)) begin
        v = (p == bad_fsb) ? prev : ~prev;
        fsb_hit.push_back(p == bad_fsb);
      end else begin
        v = rx[w - 1 - k];
        k++;
        fsb_hit.push_back(1'b0);
      end
      field.push_back(v);
      prev = v;
    end

    if (!sof_abort) noise_idle();
    bus.sof = 1'b1;
    bus.fd_iso = iso;
    bus.frame_abort = sof_abort;
    step();
    clr();
    exp_busy = 1'b1; exp_done = 1'b0; exp_crc_err = 1'b0; exp_fsb_err = 1'b0;

    foreach (calc_bits[i]) begin
      gap(1'b0);
      bus.sample_point = 1'b1;
      bus.sampled_bit  = calc_bits[i];
      bus.stuff_bit    = calc_stuff[i];
      step();
      clr();
    end

    for (int p = 0; p < len; p++) begin
      if (p > 0) gap(1'b1);
      if (p == abort_pos) begin
        bus.frame_abort = 1'b1;
        step();
        clr();
        exp_busy = 1'b0;
        return;
      end
      if (p == rst_pos) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_crc_err = 1'b0; exp_fsb_err = 1'b0; exp_calc = '0;
        return;
      end
      bus.sample_point = 1'b1;
      bus.sampled_bit  = field[p];
      if (p == 0) begin
        bus.crc_start = 1'b1;
        bus.fd_frame  = fd;
        bus.dlc       = dl;
      end else begin
        bus.stuff_bit = 1'($urandom_range(0, 1));
      end
      step();
      clr();
      if (p == 0) exp_calc = crc;
      if (fsb_hit[p]) exp_fsb_err = 1'b1;
    end
    exp_busy = 1'b0;

    bus.sample_point = 1'($urandom_range(0, 1));
    bus.sampled_bit  = 1'($urandom_range(0, 1));
    bus.crc_start    = 1'($urandom_range(0, 1));
    step();
    clr();
    exp_done = 1'b1;
    exp_crc_err = (flip != 21'd0);
    step();
    exp_done = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_crc_err = 1'b0; exp_fsb_err = 1'b0; exp_calc = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    set_bits(19, 1'b0);
    cmp("pin_crc15_zero", model_crc(15, 22'h00C599, 21'd0, 1'b1), 21'h0);
    send_frame(1'b0, 1'b0, 4'd0, 21'd0, -1, -1, -1, 1'b0);

    set_bits(1, 1'b0);
    calc_bits.push_back(1'b1);
    calc_stuff.push_back(1'b0);
    cmp("pin_crc15_01", model_crc(15, 22'h00C599, 21'd0, 1'b1), 21'h4599);
    send_frame(1'b0, 1'b0, 4'd0, 21'd0, -1, -1, -1, 1'b0);
    cmp("classic_calc_4599", bus.crc_calc, 21'h4599);
    send_frame(1'b0, 1'b0, 4'd0, 21'd1, -1, -1, -1, 1'b0);
    cmp("classic_4598_err", {20'd0, bus.crc_err}, 21'd1);

    set_bits(1, 1'b0);
    cmp("pin_crc17_iso", model_crc(17, 22'h03685B, 21'h10000, 1'b0), 21'h1685B);
    send_frame(1'b1, 1'b1, 4'd4, 21'd0, -1, -1, -1, 1'b0);
    cmp("fd17_calc", bus.crc_calc, 21'h1685B);
    send_frame(1'b1, 1'b1, 4'd4, 21'd0, 5, -1, -1, 1'b0);
    cmp("fd17_fsb_err", {20'd0, bus.fsb_err}, 21'd1);

    cmp("pin_crc21_iso", model_crc(21, 22'h302899, 21'h100000, 1'b0), 21'h102899);
    send_frame(1'b1, 1'b1, 4'd11, 21'd0, -1, 10, -1, 1'b0);
    cmp("fd21_abort_calc", bus.crc_calc, 21'h102899);

    set_bits(10, 1'b1);
    calc_bits[3] = 1'b0;
    send_frame(1'b0, 1'b0, 4'd0, 21'd0, -1, -1, 7, 1'b0);
    send_frame(1'b0, 1'b0, 4'd0, 21'd0, -1, -1, -1, 1'b0);

    bus.sof = 1'b1;
    step();
    clr();
    exp_busy = 1'b1; exp_crc_err = 1'b0; exp_fsb_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sample_point = 1'b1;
      bus.sampled_bit  = 1'($urandom_range(0, 1));
      step();
      clr();
    end
    set_bits(6, 1'b1);
    calc_bits[2] = 1'b0;
    send_frame(1'b1, 1'b0, 4'd2, 21'd0, -1, -1, -1, 1'b1);

    for (int f = 0; f < 60; f++) begin
      bit fd;
      bit iso;
      logic [3:0] dl;
      logic [20:0] flip;
      int bad;
      int ab;
      int nb;
      fd   = 1'($urandom_range(0, 1));
      iso  = 1'($urandom_range(0, 1));
      dl   = 4'($urandom_range(0, 15));
      flip = ($urandom_range(0, 3) == 0) ? (21'd1 << $urandom_range(0, 14)) : 21'd0;
      bad  = (fd && $urandom_range(0, 4) == 0) ? 5 * $urandom_range(0, 4) : -1;
      ab   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 14) : -1;
      nb   = $urandom_range(1, 40);
      calc_bits.delete();
      calc_stuff.delete();
      for (int i = 0; i < nb; i++) begin
        calc_bits.push_back(1'($urandom_range(0, 1)));
        calc_stuff.push_back($urandom_range(0, 7) == 0);
      end
      send_frame(fd, iso, dl, flip, bad, ab, -1, 1'b0);
    end

    step();
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
